// File: rtl/arm_fetch_unit.sv
// Instruction fetch stage: one-outstanding word reads into a small prefetch queue,
// with the queue head presented to decode via valid/ready; redirects flush and restart.
module arm_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StReq, StSquash} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            mem_req_q, mem_req_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d, left;
    logic            ir_valid_q, ir_valid_d;
    logic [31:0]     ir_q, ir_d, ir_pc_q, ir_pc_d;
    logic [31:0]     q_data [DEPTH];
    logic [31:0]     q_pc   [DEPTH];
    logic            fire, pop, push, space;
    logic [31:0]     target;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    always_comb begin
        fire   = mem_req_q && mem_ack;
        target = {redirect_pc[31:2], 2'b00};
        pop    = (count_q != '0) && ir_ready && !redirect;
        // Only a live (non-squashed) response is written into the queue.
        push   = fire && (state_q == StReq) && !redirect;
        left   = count_q - CW'(pop);

        if (redirect) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            rd_d    = rd_q + PW'(pop);
            wr_d    = wr_q + PW'(push);
            count_d = left + CW'(push);
        end
        space = count_d < CW'(DEPTH);

        // Head of the queue after this cycle; hold the last values when it drains.
        ir_valid_d = count_d != '0;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        if (count_d != '0) begin
            if (left == '0) begin
                ir_d    = mem_rdata;
                ir_pc_d = mem_addr_q;
            end else begin
                ir_d    = q_data[rd_d];
                ir_pc_d = q_pc[rd_d];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    pc_d       = target;
                    mem_req_d  = 1'b1;
                    mem_addr_d = target;
                    state_d    = StReq;
                end else if (space) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (redirect) begin
                    pc_d = target;
                    if (fire) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = target;
                    end else begin
                        state_d = StSquash;
                    end
                end else if (fire) begin
                    pc_d = mem_addr_q + 32'd4;
                    if (space) begin
                        mem_addr_d = mem_addr_q + 32'd4;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end
            StSquash: begin
                if (redirect) begin
                    pc_d = target;
                end
                // The stale word is dropped; fetch the latest target next.
                if (fire) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect ? target : pc_q;
                    state_d    = StReq;
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            ir_valid_q <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            ir_valid_q <= ir_valid_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_data[wr_q] <= mem_rdata;
            q_pc[wr_q]   <= mem_addr_q;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir_valid = ir_valid_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (expected queue contents, outstanding fetch, next pc).
module tb_arm_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    arm_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_ack    = 0;

    // Reference model: words expected in decode order, plus the single outstanding read.
    logic [63:0] mq[$];
    logic        m_out;
    logic [31:0] m_addr;
    logic        m_stale;
    logic [31:0] m_next;
    logic [31:0] m_ir;
    logic [31:0] m_irpc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic rdy, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] rdata);
        logic fired;
        rst         = r;
        mem_ack     = a;
        ir_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        mem_rdata   = rdata;
        if (mem_req && a && !r) n_ack++;

        if (r) begin
            mq.delete();
            m_out   = 1'b0;
            m_stale = 1'b0;
            m_next  = RESET_PC;
            m_ir    = '0;
            m_irpc  = '0;
        end else begin
            fired = m_out && a;
            if (rd) begin
                mq.delete();
                m_next = {rpc[31:2], 2'b00};
                if (m_out && !fired) begin
                    m_stale = 1'b1;
                end else begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end
            end else begin
                if (mq.size() > 0 && rdy) void'(mq.pop_front());
                if (fired) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        mq.push_back({m_addr, rdata});
                        m_next = m_addr + 32'd4;
                    end
                    m_out = 1'b0;
                end
            end
            if (!m_out && mq.size() < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_next;
            end
            if (mq.size() > 0) begin
                m_ir   = mq[0][31:0];
                m_irpc = mq[0][63:32];
            end
        end

        @(posedge clk);
        #1;
        chk("mem_req", 32'(mem_req), 32'(m_out));
        if (m_out || r) chk("mem_addr", mem_addr, r ? 32'd0 : m_addr);
        chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
        chk("ir_valid", 32'(ir_valid), 32'(mq.size() > 0));
        chk("ir", ir, m_ir);
        chk("ir_pc", ir_pc, m_irpc);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, rdy, 1'b0, 32'd0, word_of(mem_addr));
    endtask

    initial begin
        logic        r, a, rdy, rd;
        logic [31:0] rpc;
        rst = 1'b1; mem_ack = 1'b0; ir_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; mem_rdata = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Free-running fetch across the address wrap.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk("s1_a0", mem_addr, 32'hFFFF_FFF8);
        run(1, 1'b1);
        chk("s1_a1", mem_addr, 32'hFFFF_FFFC);
        chk("s1_valid", 32'(ir_valid), 32'd1);
        chk("s1_pc0", ir_pc, 32'hFFFF_FFF8);
        run(1, 1'b1);
        chk("s1_a2", mem_addr, 32'h0000_0000);
        chk("s1_pc1", ir_pc, 32'hFFFF_FFFC);
        run(1, 1'b1);
        chk("s1_a3", mem_addr, 32'h0000_0004);
        chk("s1_pc2", ir_pc, 32'h0000_0000);
        chk("s1_ir2", ir, word_of(32'h0000_0000));

        // Decode stalled: queue fills after two reads, then fetch resumes in order.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        n_ack = 0;
        run(6, 1'b0);
        chk("s2_acks", 32'(n_ack), 32'd2);
        chk("s2_req_off", 32'(mem_req), 32'd0);
        chk("s2_head", ir_pc, 32'hFFFF_FFF8);
        run(1, 1'b1);
        chk("s2_resume_req", 32'(mem_req), 32'd1);
        chk("s2_resume_addr", mem_addr, 32'h0000_0000);

        // Redirect while a read is outstanding: late word is discarded.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1003, 32'd0);
        chk("s3_flush", 32'(ir_valid), 32'd0);
        chk("s3_hold_addr", mem_addr, 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF);
        chk("s3_target", mem_addr, 32'h0000_1000);
        chk("s3_no_beef", 32'(ir_valid), 32'd0);
        run(1, 1'b0);
        chk("s3_first_pc", ir_pc, 32'h0000_1000);
        chk("s3_first_ir", ir, word_of(32'h0000_1000));

        // Redirect together with ack and pop.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3000, word_of(mem_addr));
        chk("s4_flush", 32'(ir_valid), 32'd0);
        chk("s4_req", 32'(mem_req), 32'd1);
        chk("s4_addr", mem_addr, 32'h0000_3000);

        // Two redirects while squashing: the later target wins.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'd0);
        run(1, 1'b0);
        chk("s5_addr", mem_addr, 32'h0000_2000);
        run(1, 1'b0);
        chk("s5_first_pc", ir_pc, 32'h0000_2000);

        // Reset with a read outstanding.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, word_of(mem_addr));
        chk("s6_req", 32'(mem_req), 32'd0);
        chk("s6_addr", mem_addr, 32'd0);
        chk("s6_ir", ir, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("s6_restart", mem_addr, 32'hFFFF_FFF8);

        // Random traffic; acks also arrive with no request pending.
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            a   = ($urandom_range(0, 2) != 0);
            rdy = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(r, a, rdy, rd, rpc, word_of(mem_addr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
